// File: rtl/stall_ctrl_pkg.sv
// rtl/stall_ctrl_pkg.sv - shared FSM encodings, defaults and helpers for the interlock controller
package stall_ctrl_pkg;

    // Interlock FSM states, 2-bit encoded
    typedef enum logic [1:0] {
        SC_RUN      = 2'd0,
        SC_LD_STALL = 2'd1,
        SC_MEM_WAIT = 2'd2,
        SC_DIV_WAIT = 2'd3
    } sc_state_t;

    // Default divider EXE residency and counter width (counter must hold DIV_LAT-2)
    localparam int DIV_LAT_DEFAULT = 32;
    localparam int CNT_W_DEFAULT   = 6;

    // Widths reserved for bussing the stage information into this block:
    // ID: valid + two 5-bit source addresses + two used flags
    // EXE: valid + 5-bit dest + load flag + divide start
    localparam int DS_TO_SC_BUS_WD = 13;
    localparam int ES_TO_SC_BUS_WD = 8;

    // True when a used source operand names the given destination register
    function automatic logic src_hits_dest(input logic       used,
                                           input logic [4:0] src,
                                           input logic [4:0] dest);
        return used & (src == dest);
    endfunction

endpackage

// File: rtl/stall_ctrl_ld_use_detect.sv
// rtl/stall_ctrl_ld_use_detect.sv - combinational load-use hazard detector between ID and EXE
module ld_use_detect
    import stall_ctrl_pkg::*;
(
    input  logic       i_ds_valid,
    input  logic [4:0] i_ds_rf_raddr1,
    input  logic [4:0] i_ds_rf_raddr2,
    input  logic       i_ds_src1_used,
    input  logic       i_ds_src2_used,
    input  logic       i_es_valid,
    input  logic [4:0] i_es_dest,
    input  logic       i_es_res_from_mem,
    output logic       o_ld_hazard
);

    logic w_es_load_live;
    logic w_src_hit;

    // A load only hazards when both stages are live and it writes a real register (r0 never forwards)
    assign w_es_load_live = i_ds_valid & i_es_valid & i_es_res_from_mem & (i_es_dest != 5'd0);

    // Either used source of the ID instruction reading the load's destination
    assign w_src_hit = src_hits_dest(i_ds_src1_used, i_ds_rf_raddr1, i_es_dest)
                     | src_hits_dest(i_ds_src2_used, i_ds_rf_raddr2, i_es_dest);

    assign o_ld_hazard = w_es_load_live & w_src_hit;

endmodule

// File: rtl/stall_ctrl.sv
// rtl/stall_ctrl.sv - pipeline interlock FSM for load-use stalls and multi-cycle divides
module stall_ctrl
    import stall_ctrl_pkg::*;
#(
    parameter int DIV_LAT = DIV_LAT_DEFAULT,
    parameter int CNT_W   = CNT_W_DEFAULT
)(
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic        ds_valid,
    input  logic [4:0]  ds_rf_raddr1,
    input  logic [4:0]  ds_rf_raddr2,
    input  logic        ds_src1_used,
    input  logic        ds_src2_used,
    input  logic        es_valid,
    input  logic [4:0]  es_dest,
    input  logic        es_res_from_mem,
    input  logic        es_div_start,
    input  logic        ms_data_ok,
    output logic        fs_stall,
    output logic        ds_stall,
    output logic        es_bubble,
    output logic        es_stall,
    output logic        ms_bubble,
    output logic        div_done,
    output logic [31:0] stall_cycles
);

    // The start cycle and the release cycle are spent outside DIV_WAIT's stalled stretch
    localparam logic [CNT_W-1:0] DIV_CNT_INIT = CNT_W'(DIV_LAT - 2);

    sc_state_t        r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [31:0]      r_stall_cycles;

    logic w_ld_hazard;
    logic w_cnt_zero;
    logic w_ds_stall;
    logic w_es_bubble;
    logic w_es_stall;
    logic w_div_done;

    ld_use_detect u_ld_use_detect (
        .i_ds_valid        (ds_valid),
        .i_ds_rf_raddr1    (ds_rf_raddr1),
        .i_ds_rf_raddr2    (ds_rf_raddr2),
        .i_ds_src1_used    (ds_src1_used),
        .i_ds_src2_used    (ds_src2_used),
        .i_es_valid        (es_valid),
        .i_es_dest         (es_dest),
        .i_es_res_from_mem (es_res_from_mem),
        .o_ld_hazard       (w_ld_hazard)
    );

    assign w_cnt_zero = (r_cnt == '0);

    // Stall/bubble decode from state and live inputs; flush or reset silences everything at once
    always_comb begin
        w_ds_stall  = 1'b0;
        w_es_bubble = 1'b0;
        w_es_stall  = 1'b0;
        w_div_done  = 1'b0;
        case (r_state)
            SC_RUN: begin
                w_ds_stall  = w_ld_hazard | es_div_start;
                w_es_bubble = w_ld_hazard;
                w_es_stall  = es_div_start;
            end
            SC_LD_STALL, SC_MEM_WAIT: begin
                w_ds_stall  = ~ms_data_ok;
                w_es_bubble = ~ms_data_ok;
            end
            SC_DIV_WAIT: begin
                w_ds_stall  = ~w_cnt_zero;
                w_es_stall  = ~w_cnt_zero;
                w_div_done  = w_cnt_zero;
            end
            default: begin
                w_ds_stall  = 1'b0;
            end
        endcase
        if (flush || reset) begin
            w_ds_stall  = 1'b0;
            w_es_bubble = 1'b0;
            w_es_stall  = 1'b0;
            w_div_done  = 1'b0;
        end
    end

    assign fs_stall     = w_ds_stall;
    assign ds_stall     = w_ds_stall;
    assign es_bubble    = w_es_bubble;
    assign es_stall     = w_es_stall;
    assign ms_bubble    = w_es_stall;
    assign div_done     = w_div_done;
    assign stall_cycles = r_stall_cycles;

    // Interlock FSM and divide down-counter; divide start wins over a simultaneous load-use hazard
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= SC_RUN;
            r_cnt   <= '0;
        end else if (flush) begin
            r_state <= SC_RUN;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                SC_RUN: begin
                    if (es_div_start) begin
                        r_state <= SC_DIV_WAIT;
                        r_cnt   <= DIV_CNT_INIT;
                    end else if (w_ld_hazard) begin
                        r_state <= SC_LD_STALL;
                    end
                end
                SC_LD_STALL: begin
                    r_state <= ms_data_ok ? SC_RUN : SC_MEM_WAIT;
                end
                SC_MEM_WAIT: begin
                    if (ms_data_ok) begin
                        r_state <= SC_RUN;
                    end
                end
                SC_DIV_WAIT: begin
                    if (w_cnt_zero) begin
                        r_state <= SC_RUN;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= SC_RUN;
                end
            endcase
        end
    end

    // Performance counter of ID-stall cycles, free-running with natural 32-bit wrap
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stall_cycles <= 32'd0;
        end else if (w_ds_stall) begin
            r_stall_cycles <= r_stall_cycles + 32'd1;
        end
    end

endmodule

// File: tb/tb_stall_ctrl.sv
// tb/tb_stall_ctrl.sv - self-checking bench for the interlock controller
module tb_stall_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        flush = 1'b0;
    logic        ds_valid = 1'b0;
    logic [4:0]  ds_rf_raddr1 = 5'd0;
    logic [4:0]  ds_rf_raddr2 = 5'd0;
    logic        ds_src1_used = 1'b0;
    logic        ds_src2_used = 1'b0;
    logic        es_valid = 1'b0;
    logic [4:0]  es_dest = 5'd0;
    logic        es_res_from_mem = 1'b0;
    logic        es_div_start = 1'b0;
    logic        ms_data_ok = 1'b0;
    logic        fs_stall;
    logic        ds_stall;
    logic        es_bubble;
    logic        es_stall;
    logic        ms_bubble;
    logic        div_done;
    logic [31:0] stall_cycles;

    int n_cmp = 0;
    int n_bad = 0;

    stall_ctrl #(.DIV_LAT(32), .CNT_W(6)) dut (
        .clk             (clk),
        .reset           (reset),
        .flush           (flush),
        .ds_valid        (ds_valid),
        .ds_rf_raddr1    (ds_rf_raddr1),
        .ds_rf_raddr2    (ds_rf_raddr2),
        .ds_src1_used    (ds_src1_used),
        .ds_src2_used    (ds_src2_used),
        .es_valid        (es_valid),
        .es_dest         (es_dest),
        .es_res_from_mem (es_res_from_mem),
        .es_div_start    (es_div_start),
        .ms_data_ok      (ms_data_ok),
        .fs_stall        (fs_stall),
        .ds_stall        (ds_stall),
        .es_bubble       (es_bubble),
        .es_stall        (es_stall),
        .ms_bubble       (ms_bubble),
        .div_done        (div_done),
        .stall_cycles    (stall_cycles)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       flush;
        logic       ds_valid;
        logic [4:0] raddr1;
        logic [4:0] raddr2;
        logic       src1_used;
        logic       src2_used;
        logic       es_valid;
        logic [4:0] es_dest;
        logic       es_mem;
        logic       div_start;
        logic       data_ok;
        logic       e_ds_stall;
        logic       e_es_bubble;
        logic       e_es_stall;
    } vec_t;

    vec_t tbl [13];
    int   exp_sc;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic chk_outs(input string nm, input logic e_ds, input logic e_bub,
                            input logic e_es, input logic e_done);
        chk({nm, ".ds_stall"},  {31'd0, ds_stall},  {31'd0, e_ds});
        chk({nm, ".fs_stall"},  {31'd0, fs_stall},  {31'd0, e_ds});
        chk({nm, ".es_bubble"}, {31'd0, es_bubble}, {31'd0, e_bub});
        chk({nm, ".es_stall"},  {31'd0, es_stall},  {31'd0, e_es});
        chk({nm, ".ms_bubble"}, {31'd0, ms_bubble}, {31'd0, e_es});
        chk({nm, ".div_done"},  {31'd0, div_done},  {31'd0, e_done});
    endtask

    task automatic idle_inputs();
        flush = 1'b0; ds_valid = 1'b0; ds_rf_raddr1 = 5'd0; ds_rf_raddr2 = 5'd0;
        ds_src1_used = 1'b0; ds_src2_used = 1'b0; es_valid = 1'b0; es_dest = 5'd0;
        es_res_from_mem = 1'b0; es_div_start = 1'b0; ms_data_ok = 1'b0;
    endtask

    task automatic set_hazard();
        ds_valid = 1'b1; ds_rf_raddr1 = 5'd5; ds_src1_used = 1'b1;
        es_valid = 1'b1; es_dest = 5'd5; es_res_from_mem = 1'b1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    // Load-use: hazard at cycle 0, data_ok arrives ok_at cycles later
    task automatic ld_seq(input string nm, input int ok_at);
        set_hazard();
        @(negedge clk);
        chk_outs({nm, ".c0"}, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        es_valid = 1'b0; es_dest = 5'd0; es_res_from_mem = 1'b0;
        for (int c = 1; c <= ok_at; c++) begin
            ms_data_ok = (c == ok_at);
            @(negedge clk);
            chk($sformatf("%s.c%0d.ds_stall", nm, c), {31'd0, ds_stall}, {31'd0, (c != ok_at)});
            chk($sformatf("%s.c%0d.es_bubble", nm, c), {31'd0, es_bubble}, {31'd0, (c != ok_at)});
            tick();
        end
        idle_inputs();
        @(negedge clk);
        chk({nm, ".back_in_run"}, {31'd0, ds_stall}, 32'd0);
        tick();
    endtask

    initial begin
        //            fl dv  rA1    rA2   u1 u2 ev dest  mem div ok  ds bub es
        tbl[0]  = '{1'b0,1'b0,5'd0,5'd0,1'b0,1'b0,1'b0,5'd0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0};
        tbl[1]  = '{1'b0,1'b1,5'd5,5'd0,1'b1,1'b0,1'b1,5'd5,1'b1,1'b0,1'b0, 1'b1,1'b1,1'b0};
        tbl[2]  = '{1'b0,1'b1,5'd3,5'd7,1'b0,1'b1,1'b1,5'd7,1'b1,1'b0,1'b0, 1'b1,1'b1,1'b0};
        tbl[3]  = '{1'b0,1'b1,5'd0,5'd0,1'b1,1'b1,1'b1,5'd0,1'b1,1'b0,1'b0, 1'b0,1'b0,1'b0};
        tbl[4]  = '{1'b0,1'b1,5'd5,5'd0,1'b0,1'b1,1'b1,5'd5,1'b1,1'b0,1'b0, 1'b0,1'b0,1'b0};
        tbl[5]  = '{1'b0,1'b1,5'd5,5'd0,1'b1,1'b0,1'b1,5'd5,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0};
        tbl[6]  = '{1'b0,1'b0,5'd5,5'd0,1'b1,1'b0,1'b1,5'd5,1'b1,1'b0,1'b0, 1'b0,1'b0,1'b0};
        tbl[7]  = '{1'b0,1'b1,5'd5,5'd0,1'b1,1'b0,1'b0,5'd5,1'b1,1'b0,1'b0, 1'b0,1'b0,1'b0};
        tbl[8]  = '{1'b0,1'b1,5'd4,5'd6,1'b1,1'b1,1'b1,5'd5,1'b1,1'b0,1'b0, 1'b0,1'b0,1'b0};
        tbl[9]  = '{1'b0,1'b0,5'd0,5'd0,1'b0,1'b0,1'b1,5'd9,1'b0,1'b1,1'b0, 1'b1,1'b0,1'b1};
        tbl[10] = '{1'b0,1'b1,5'd5,5'd0,1'b1,1'b0,1'b1,5'd5,1'b1,1'b1,1'b0, 1'b1,1'b1,1'b1};
        tbl[11] = '{1'b0,1'b1,5'd5,5'd0,1'b1,1'b0,1'b1,5'd5,1'b1,1'b0,1'b1, 1'b1,1'b1,1'b0};
        tbl[12] = '{1'b1,1'b1,5'd5,5'd0,1'b1,1'b0,1'b1,5'd5,1'b1,1'b1,1'b0, 1'b0,1'b0,1'b0};

        // Outputs forced low while reset is held, even with hazard and divide start present
        set_hazard();
        es_div_start = 1'b1;
        @(negedge clk);
        chk_outs("reset", 1'b0, 1'b0, 1'b0, 1'b0);
        chk("reset.stall_cycles", stall_cycles, 32'd0);
        idle_inputs();
        tick();
        reset = 1'b0;

        // Single-cycle decode in RUN; a flush cycle after each vector returns to RUN
        exp_sc = 0;
        for (int i = 0; i < 13; i++) begin
            flush = tbl[i].flush; ds_valid = tbl[i].ds_valid;
            ds_rf_raddr1 = tbl[i].raddr1; ds_rf_raddr2 = tbl[i].raddr2;
            ds_src1_used = tbl[i].src1_used; ds_src2_used = tbl[i].src2_used;
            es_valid = tbl[i].es_valid; es_dest = tbl[i].es_dest;
            es_res_from_mem = tbl[i].es_mem; es_div_start = tbl[i].div_start;
            ms_data_ok = tbl[i].data_ok;
            @(negedge clk);
            chk_outs($sformatf("vec%0d", i), tbl[i].e_ds_stall, tbl[i].e_es_bubble,
                     tbl[i].e_es_stall, 1'b0);
            exp_sc += int'(tbl[i].e_ds_stall);
            tick();
            idle_inputs();
            flush = 1'b1;
            @(negedge clk);
            chk($sformatf("vec%0d.flush_cycle", i), {31'd0, ds_stall}, 32'd0);
            tick();
            flush = 1'b0;
        end
        chk("table.stall_cycles", stall_cycles, exp_sc);

        // Load-use penalties of 1, 2 and 4 cycles
        do_reset();
        ld_seq("ld_ok1", 1);
        ld_seq("ld_ok2", 2);
        ld_seq("ld_ok4", 4);
        chk("ld.stall_cycles", stall_cycles, 32'd7);

        // Full divide: 31 stalled cycles, done on cycle 32, nothing on 33
        do_reset();
        es_div_start = 1'b1;
        @(negedge clk);
        chk_outs("div.c1", 1'b1, 1'b0, 1'b1, 1'b0);
        tick();
        es_div_start = 1'b0;
        for (int k = 2; k <= 32; k++) begin
            @(negedge clk);
            chk_outs($sformatf("div.c%0d", k), (k <= 31), 1'b0, (k <= 31), (k == 32));
            tick();
        end
        @(negedge clk);
        chk_outs("div.c33", 1'b0, 1'b0, 1'b0, 1'b0);
        chk("div.stall_cycles", stall_cycles, 32'd31);

        // Flush on cycle 10 of a divide aborts it with no done pulse
        do_reset();
        es_div_start = 1'b1;
        tick();
        es_div_start = 1'b0;
        for (int k = 2; k <= 9; k++) tick();
        flush = 1'b1;
        @(negedge clk);
        chk_outs("divfl.c10", 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        flush = 1'b0;
        for (int k = 11; k <= 50; k++) begin
            @(negedge clk);
            chk($sformatf("divfl.c%0d.div_done", k), {31'd0, div_done}, 32'd0);
            chk($sformatf("divfl.c%0d.es_stall", k), {31'd0, es_stall}, 32'd0);
            tick();
        end
        chk("divfl.stall_cycles", stall_cycles, 32'd9);

        // Asynchronous reset while waiting in MEM_WAIT
        do_reset();
        set_hazard();
        tick();
        es_valid = 1'b0; es_dest = 5'd0; es_res_from_mem = 1'b0;
        tick();
        @(negedge clk);
        chk("rstmw.held", {31'd0, ds_stall}, 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk_outs("rstmw.async", 1'b0, 1'b0, 1'b0, 1'b0);
        chk("rstmw.stall_cycles", stall_cycles, 32'd0);
        tick();
        reset = 1'b0;
        @(negedge clk);
        chk_outs("rstmw.run", 1'b0, 1'b0, 1'b0, 1'b0);
        chk("rstmw.stall_cycles_after", stall_cycles, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
